// File: rtl/fp_mult_result_fifo.sv
// Result buffer behind the pipelined FP multiplier.
// Holds z/status pairs until the consumer takes them, hands out issue credits
// so every launched operation has a reserved slot, and keeps sticky exception
// flags, a saturating result count and sticky protocol-error bits.
module fp_mult_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             issue_ok,
  input  logic             in_valid,
  input  logic [31:0]      in_z,
  input  logic [7:0]       in_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [7:0]       out_status,
  output logic [7:0]       sticky,
  input  logic             clear_sticky,
  output logic [CNT_W-1:0] result_cnt,
  output logic [2:0]       err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      OCC_MAX  = {(AW+1){1'b1}};
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Storage: {z, status} per entry. Read is asynchronous so the head is
  // visible the cycle after it was written, with no extra output register.
  logic [39:0] mem_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      inflight_q, inflight_d;
  logic [7:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q, err_d;

  logic            full;
  logic            push;
  logic            pop;
  logic            dropped;
  logic            spurious;
  logic            overrun;
  logic [AW+1:0]   reserved;

  // Handshake decode and next-state computation for every register.
  always_comb begin
    full      = (count_q == DEPTH_C);
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    push      = in_valid && (!full || pop);
    dropped   = in_valid && full && !pop;
    spurious  = in_valid && !issue && (inflight_q == '0);

    // Credits count both stored entries and results still inside the
    // multiplier; only registered state feeds this.
    reserved  = {1'b0, count_q} + {1'b0, inflight_q};
    issue_ok  = (reserved < {1'b0, DEPTH_C});
    overrun   = issue && !issue_ok;

    wptr_d = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d = pop  ? (rptr_q + PTR_ONE) : rptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + OCC_ONE;
    end else if (pop && !push) begin
      count_d = count_q - OCC_ONE;
    end

    // Overrun issues keep counting; hold at the top rather than wrapping.
    inflight_d = inflight_q;
    if (issue && !in_valid) begin
      if (inflight_q != OCC_MAX) begin
        inflight_d = inflight_q + OCC_ONE;
      end
    end else if (in_valid && !issue && (inflight_q != '0)) begin
      inflight_d = inflight_q - OCC_ONE;
    end

    // Clearing wins over a coinciding push or error event.
    if (clear_sticky) begin
      sticky_d = '0;
      cnt_d    = '0;
      err_d    = '0;
    end else begin
      sticky_d = push ? (sticky_q | in_status) : sticky_q;
      cnt_d    = (push && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;
      err_d    = err_q | {spurious, dropped, overrun};
    end

    {out_z, out_status} = mem_q[rptr_q];
    sticky     = sticky_q;
    result_cnt = cnt_q;
    err        = err_q;
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      sticky_q   <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Entry write; the array carries no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wptr_q] <= {in_z, in_status};
    end
  end

endmodule

// File: doc/fp_mult_result_fifo.md
# fp_mult_result_fifo

Result buffer directly downstream of the pipelined FP multiplier. Captures each `z`/`status` pair the multiplier emits, holds it in a small FIFO until the consumer takes it with a valid/ready handshake, and issues credits upstream so the multiplier is never launched without a guaranteed slot. Accumulates sticky exception flags and a saturating result count for software visibility.

## Interface
- `DEPTH`, 4: FIFO entries. Legal values are powers of two, ≥ 4.
- `CNT_W`, 16: width of `result_cnt`.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `issue` input 1: an operand pair enters the multiplier this cycle.
- `issue_ok` output 1: a credit is available, so `issue` is permitted this cycle.
- `in_valid` input 1: multiplier output is valid this cycle.
- `in_z` input 32: multiplier result.
- `in_status` input 8: multiplier status. Bits are [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [7:5] reserved.
- `out_valid` output 1: the FIFO head is valid.
- `out_ready` input 1: the consumer accepts the head.
- `out_z` output 32: head result.
- `out_status` output 8: head status.
- `sticky` output 8: OR of `in_status` over all accepted results since the last clear.
- `clear_sticky` input 1: zeroes `sticky` and `result_cnt`.
- `result_cnt` output CNT_W: accepted results, saturating at all-ones.
- `err` output 3: sticky errors. [0] overrun issue, [1] push dropped while full, [2] spurious `in_valid` with nothing in flight. Cleared by `clear_sticky`.

## Operation
- **Storage.** Circular buffer of DEPTH entries, 40 bits each (`z`, `status`).
  - Write pointer and read pointer are log2(DEPTH) bits wide and wrap naturally.
  - Occupancy `count` is log2(DEPTH)+1 bits wide.
- **Push.** Occurs when `in_valid` and (`count < DEPTH` or pop this cycle).
  - Writes `{in_z, in_status}` at the write pointer.
  - Increments the write pointer.
- **Pop.** Occurs when `out_valid && out_ready`. Increments the read pointer.
- **Count update.** +1 on push only, −1 on pop only, unchanged on both or neither.
- **Dropped push.** `in_valid` while full with no pop drops the data. Sets `err[1]`. The FIFO, `sticky` and `result_cnt` are unchanged.
- **Head outputs.** `out_valid = (count != 0)`. `out_z`/`out_status` = the entry at the read pointer. Undefined (don't care) while `out_valid` is 0.
- **In-flight tracking.** `inflight` counter, log2(DEPTH)+1 bits wide.
  - +1 on `issue`, −1 on `in_valid`, unchanged on both.
  - `in_valid` with `inflight == 0` and no `issue` sets `err[2]` and leaves `inflight` at 0.
- **Credit.** `issue_ok = (count + inflight) < DEPTH`, decoded from registers only. It does not depend on `out_ready` in the same cycle.
  - `issue` while `issue_ok` is 0 sets `err[0]` and is still counted in `inflight`.
- **Sticky flags.** On each accepted push, `sticky <= sticky | in_status`.
  - `clear_sticky` takes priority: if it coincides with a push, `sticky <= 0`, `result_cnt <= 0`, `err <= 0`. The coinciding push's flags and count are lost.
- **Result count.** `result_cnt` increments on each accepted push and holds at 2^CNT_W−1.
- **Reset.** `rst` high at an edge sets all of the following to 0: pointers, `count`, `inflight`, `sticky`, `result_cnt`, `err`.
  - After reset, `out_valid = 0` and `issue_ok = 1`.
  - Results in flight inside the multiplier when reset is applied are not retained. A post-reset `in_valid` sets `err[2]`; this is expected.

## Timing
- Push at edge t makes the entry visible with `out_valid = 1` after edge t, so the head is poppable in cycle t+1. No bypass from `in_*` to `out_*` in the same cycle.
- Pop and push in the same cycle on a full FIFO: both occur and `count` stays at DEPTH.
- Pop at edge t: the next entry appears on `out_*` after edge t.
- `issue_ok` reflects state after the previous edge.
- Multiplier latency is not a parameter here. The credit scheme covers any latency, because slots are reserved at issue.
- `sticky`, `result_cnt` and `err` are registered and update one edge after the causing event.

## Test plan
- **Reset values.** Hold `rst` 2 cycles → `out_valid = 0`, `issue_ok = 1`, `sticky = 0`, `result_cnt = 0`, `err = 0`.
- **Credit limit.** Issue 4 back-to-back and return `in_valid` 3 cycles later with `z` = 0x3F800000, 0x40000000, 0x40400000, 0x40800000, with `out_ready = 0`.
  - Expect `issue_ok = 0` from the cycle after the 4th issue.
  - Then raise `out_ready`: expect the four values out in order, and `issue_ok` returns 1 after the first pop.
- **Simultaneous push/pop.** FIFO full with `out_ready = 1` and `in_valid` asserted in the same cycle.
  - Expect `count` to stay at 4, no `err[1]`, and the new entry to become the tail.
- **Error flags.**
  - `issue` with `issue_ok = 0` → `err[0] = 1`.
  - Force `in_valid` with nothing in flight → `err[2] = 1`.
  - Full, no pop, `in_valid` → `err[1] = 1`, data dropped, `result_cnt` unchanged.
- **Sticky accumulation.** Push results with status 0x01, then 0x04, then 0x10 → `sticky = 0x15` and `result_cnt = 3`.
  - `clear_sticky` coincident with a push of status 0x02 → `sticky = 0`, `result_cnt = 0`.
- **Saturation and reset mid-operation.**
  - Force `result_cnt` to 0xFFFE and push 3 → `result_cnt` holds at 0xFFFF.
  - Assert `rst` with 2 entries stored → the next cycle shows `out_valid = 0`, `count = 0`, `issue_ok = 1`.
